// File: rtl/evg_pkg.sv
// Shared EVG definitions: reserved event codes, sequence-table entry layout and player states.
// Entry layout is {delay, code}; the code sits in the low byte for every consumer.
package evg_pkg;

  localparam logic [7:0] EVCODE_END_SEQUENCE = 8'h7F;
  localparam logic [7:0] EVCODE_IDLE         = 8'h00;

  localparam int ENTRY_CODE_LSB  = 0;
  localparam int ENTRY_CODE_W    = 8;
  localparam int ENTRY_DELAY_LSB = ENTRY_CODE_LSB + ENTRY_CODE_W;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_FETCH = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_EMIT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/evg_seq_ram.sv
// Sequence table storage: one write port, one registered read port, single clock.
// Read data appears the cycle after the address; a same-cycle write to that address returns old data.
module evg_seq_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/evg_sequence_player.sv
// Plays the timed event table into the EVG sequence-event slot; first event 2+d0 cycles after trigger.
// No back-pressure: the core always accepts, so one slot per tx clock is produced unconditionally.
module evg_sequence_player
  import evg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DELAY_WIDTH = 24
) (
  input  logic                   evgTxClk,
  input  logic                   evgTxRst_n,
  input  logic                   tblWrEnable,
  input  logic [ADDR_WIDTH-1:0]  tblWrAddr,
  input  logic [DELAY_WIDTH+7:0] tblWrData,
  input  logic                   sequenceEnable,
  input  logic                   sequenceTrigger,
  input  logic                   overrunClear,
  output logic [7:0]             evgSequenceEventTDATA,
  output logic                   evgSequenceEventTVALID,
  output logic                   sequenceBusy,
  output logic                   sequenceDoneToggle,
  output logic                   triggerOverrun
);

  localparam int EW = DELAY_WIDTH + ENTRY_CODE_W;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  seq_state_e             state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]             code_q, code_d;
  logic                   last_q, last_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [7:0]             tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;
  logic                   cmpl_q, cmpl_d;

  logic [EW-1:0]          rd_entry;
  logic [7:0]             ent_code;
  logic [DELAY_WIDTH-1:0] ent_delay;
  logic                   take_entry;
  logic                   slot_now;
  logic [7:0]             slot_code;

  // The RAM output register doubles as the prefetch slot: ptr_d is always the next entry to consume.
  evg_seq_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (EW)
  ) u_ram (
    .clk     (evgTxClk),
    .wr_en   (tblWrEnable),
    .wr_addr (tblWrAddr),
    .wr_data (tblWrData),
    .rd_addr (ptr_d),
    .rd_data (rd_entry)
  );

  assign ent_code  = rd_entry[ENTRY_CODE_LSB +: ENTRY_CODE_W];
  assign ent_delay = rd_entry[ENTRY_DELAY_LSB +: DELAY_WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    last_d     = last_q;
    ptr_d      = ptr_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    cmpl_d     = 1'b0;
    take_entry = 1'b0;
    slot_now   = 1'b0;
    slot_code  = code_q;

    unique case (state_q)
      SEQ_IDLE: begin
        ptr_d = '0;
        if (sequenceTrigger && sequenceEnable && !cmpl_q) begin
          state_d = SEQ_FETCH;
          busy_d  = 1'b1;
        end
      end
      SEQ_FETCH: take_entry = 1'b1;
      SEQ_WAIT: begin
        if (cnt_q == '0) begin
          slot_now = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SEQ_EMIT: begin
        // The entry just emitted was the top address: finish one cycle after its slot.
        if (last_q) begin
          state_d = SEQ_IDLE;
          busy_d  = 1'b0;
          done_d  = ~done_q;
          cmpl_d  = 1'b1;
        end else begin
          take_entry = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    if (take_entry) begin
      ptr_d  = ptr_q + 1'b1;
      last_d = (ptr_q == LAST_ADDR);
      code_d = ent_code;
      if (ent_delay == '0) begin
        slot_now  = 1'b1;
        slot_code = ent_code;
      end else begin
        cnt_d   = ent_delay - 1'b1;
        state_d = SEQ_WAIT;
      end
    end

    // Outputs are registered, so the slot decision is made one cycle ahead of the slot itself.
    if (slot_now) begin
      if (slot_code == EVCODE_END_SEQUENCE) begin
        state_d = SEQ_IDLE;
        busy_d  = 1'b0;
        done_d  = ~done_q;
        cmpl_d  = 1'b1;
      end else begin
        state_d = SEQ_EMIT;
        if (slot_code != EVCODE_IDLE) begin
          tvalid_d = 1'b1;
          tdata_d  = slot_code;
        end
      end
    end

    if (!sequenceEnable && (state_q != SEQ_IDLE)) begin
      state_d  = SEQ_IDLE;
      busy_d   = 1'b0;
      tvalid_d = 1'b0;
      done_d   = done_q;
      cmpl_d   = 1'b0;
    end

    // The completion cycle still counts as busy for trigger purposes.
    if (sequenceTrigger && ((state_q != SEQ_IDLE) || cmpl_q)) begin
      ovr_d = 1'b1;
    end else if (overrunClear) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      state_q  <= SEQ_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      last_q   <= 1'b0;
      ptr_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      cmpl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      last_q   <= last_d;
      ptr_q    <= ptr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      cmpl_q   <= cmpl_d;
    end
  end

  assign evgSequenceEventTDATA  = tdata_q;
  assign evgSequenceEventTVALID = tvalid_q;
  assign sequenceBusy           = busy_q;
  assign sequenceDoneToggle     = done_q;
  assign triggerOverrun         = ovr_q;

endmodule

// File: tb/tb_evg_sequence_player.sv
// Directed and randomized playback checks against a slot-schedule model of the sequence table.
module tb_evg_sequence_player;

  localparam int AW = 3;
  localparam int DW = 6;
  localparam int N  = 1 << AW;
  localparam int HZ = 1024;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW+7:0] wr_data = '0;
  logic          en = 1'b1;
  logic          trig = 1'b0;
  logic          oclr = 1'b0;
  logic [7:0]    tdata;
  logic          tvalid, busy, done_t, ovr;

  always #5 clk = ~clk;

  evg_sequence_player #(
    .ADDR_WIDTH  (AW),
    .DELAY_WIDTH (DW)
  ) dut (
    .evgTxClk               (clk),
    .evgTxRst_n             (rst_n),
    .tblWrEnable            (wr_en),
    .tblWrAddr              (wr_addr),
    .tblWrData              (wr_data),
    .sequenceEnable         (en),
    .sequenceTrigger        (trig),
    .overrunClear           (oclr),
    .evgSequenceEventTDATA  (tdata),
    .evgSequenceEventTVALID (tvalid),
    .sequenceBusy           (busy),
    .sequenceDoneToggle     (done_t),
    .triggerOverrun         (ovr)
  );

  int         n_assert = 0;
  int         n_fail = 0;
  string      tname = "init";
  int         tbl_d [N];
  logic [7:0] tbl_c [N];
  bit         exp_vld [HZ];
  logic [7:0] exp_dat [HZ];
  bit         exp_busy [HZ];
  int         end_o = NEVER;
  bit         done_base = 1'b0;
  bit         model_done = 1'b0;
  bit         exp_ovr = 1'b0;
  int         o_cur = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s %s: observed %0h expected %0h", tname, tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slot k = slot(k-1) + 1 + d_k with slot(-1) = trigger + 1; end marker completes at its slot,
  // a table without one completes one cycle after the top entry's slot.
  function automatic void build_exp();
    int slot;
    for (int o = 0; o < HZ; o++) begin
      exp_vld[o] = 1'b0; exp_dat[o] = 8'h00; exp_busy[o] = 1'b0;
    end
    slot  = 1;
    end_o = NEVER;
    for (int k = 0; k < N; k++) begin
      slot = slot + 1 + tbl_d[k];
      if (tbl_c[k] == 8'h7F) begin
        end_o = slot;
        break;
      end
      if (tbl_c[k] != 8'h00) begin
        exp_vld[slot] = 1'b1;
        exp_dat[slot] = tbl_c[k];
      end
      if (k == N - 1) end_o = slot + 1;
    end
    for (int o = 1; o < end_o && o < HZ; o++) exp_busy[o] = 1'b1;
  endfunction

  function automatic void cut_after(input int a);
    for (int o = a + 1; o < HZ; o++) begin
      exp_vld[o] = 1'b0; exp_busy[o] = 1'b0;
    end
    end_o = NEVER;
  endfunction

  task automatic check_cycle(input int o);
    chk($sformatf("tvalid@%0d", o), 32'(tvalid), 32'(exp_vld[o]));
    if (exp_vld[o]) chk($sformatf("tdata@%0d", o), 32'(tdata), 32'(exp_dat[o]));
    chk($sformatf("busy@%0d", o), 32'(busy), 32'(exp_busy[o]));
    chk($sformatf("done@%0d", o), 32'(done_t), 32'(done_base ^ (o >= end_o)));
    chk($sformatf("overrun@%0d", o), 32'(ovr), 32'(exp_ovr));
  endtask

  task automatic run_to(input int last);
    while (o_cur < last && o_cur < HZ - 1) begin
      step();
      o_cur++;
      trig = 1'b0; oclr = 1'b0; wr_en = 1'b0;
      check_cycle(o_cur);
    end
  endtask

  task automatic start_play();
    build_exp();
    done_base = model_done;
    o_cur = 0;
    trig = 1'b1;
    check_cycle(0);
  endtask

  task automatic finish_play();
    run_to(end_o + 2);
    model_done = ~model_done;
  endtask

  task automatic set_entry(input int k, input int d, input logic [7:0] c);
    tbl_d[k] = d;
    tbl_c[k] = c;
  endtask

  task automatic load_table();
    logic [DW-1:0] dd;
    for (int k = 0; k < N; k++) begin
      dd = tbl_d[k][DW-1:0];
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = {dd, tbl_c[k]};
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic rand_table(input int maxd, input bit allow_end);
    int endpos;
    logic [7:0] c;
    endpos = allow_end ? int'($urandom_range(0, N - 1)) : N;
    for (int k = 0; k < N; k++) begin
      tbl_d[k] = int'($urandom_range(0, maxd));
      if (k == endpos) begin
        tbl_c[k] = 8'h7F;
      end else if ($urandom_range(0, 4) == 0) begin
        tbl_c[k] = 8'h00;
      end else begin
        c = 8'($urandom_range(1, 255));
        tbl_c[k] = (c == 8'h7F) ? 8'h80 : c;
      end
    end
    load_table();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tname = "reset";
    step();
    chk("tvalid", 32'(tvalid), 32'd0);
    chk("tdata", 32'(tdata), 32'd0);
    chk("busy", 32'(busy), 32'd0);
    chk("done", 32'(done_t), 32'd0);
    chk("overrun", 32'(ovr), 32'd0);
    rst_n = 1'b1;
    step();

    tname = "basic";
    for (int k = 0; k < N; k++) set_entry(k, 0, 8'h55);
    set_entry(0, 3, 8'h01); set_entry(1, 0, 8'h02); set_entry(2, 0, 8'h7F);
    load_table();
    start_play(); finish_play();

    tname = "gap";
    set_entry(0, 0, 8'h00); set_entry(1, 4, 8'h10); set_entry(2, 0, 8'h7F);
    load_table();
    start_play(); finish_play();

    tname = "overrun";
    set_entry(0, 3, 8'h01); set_entry(1, 0, 8'h02); set_entry(2, 0, 8'h7F);
    load_table();
    start_play();
    run_to(2);
    trig = 1'b1; exp_ovr = 1'b1;
    run_to(4);
    trig = 1'b1; oclr = 1'b1;
    finish_play();
    oclr = 1'b1; exp_ovr = 1'b0;
    run_to(o_cur + 2);

    tname = "cmpl_trig";
    start_play();
    run_to(end_o);
    trig = 1'b1; exp_ovr = 1'b1;
    finish_play();
    run_to(o_cur + 4);
    oclr = 1'b1; exp_ovr = 1'b0;
    run_to(o_cur + 2);

    tname = "abort";
    set_entry(0, 2, 8'h11); set_entry(1, 6, 8'h22); set_entry(2, 1, 8'h33); set_entry(3, 0, 8'h7F);
    load_table();
    start_play();
    run_to(7);
    en = 1'b0; cut_after(7);
    run_to(16);
    en = 1'b1;
    run_to(18);

    tname = "en_low_trig";
    en = 1'b0;
    build_exp(); cut_after(-1); done_base = model_done;
    o_cur = 0; trig = 1'b1; check_cycle(0);
    run_to(5);
    en = 1'b1;

    tname = "midwrite";
    set_entry(0, 20, 8'h31); set_entry(1, 0, 8'h32); set_entry(2, 0, 8'h33); set_entry(3, 0, 8'h7F);
    load_table();
    start_play();
    run_to(5);
    wr_en = 1'b1; wr_addr = AW'(2); wr_data = {6'd1, 8'h5A};
    set_entry(2, 1, 8'h5A);
    build_exp();
    finish_play();

    tname = "maxdelay";
    set_entry(0, 63, 8'h61); set_entry(1, 63, 8'h62); set_entry(2, 0, 8'h7F);
    load_table();
    start_play(); finish_play();

    tname = "wrap";
    for (int k = 0; k < N; k++) set_entry(k, 0, 8'(8'h20 + k));
    load_table();
    start_play(); finish_play();
    tname = "wrap_again";
    start_play(); finish_play();

    for (int it = 0; it < 10; it++) begin
      tname = $sformatf("rand%0d", it);
      rand_table(5, (it % 4) != 0);
      start_play(); finish_play();
    end

    tname = "async_rst";
    for (int k = 0; k < N; k++) set_entry(k, 0, 8'h55);
    set_entry(0, 10, 8'h44); set_entry(1, 0, 8'h7F);
    load_table();
    start_play();
    run_to(5);
    rst_n = 1'b0;
    #1;
    chk("tvalid_now", 32'(tvalid), 32'd0);
    chk("tdata_now", 32'(tdata), 32'd0);
    chk("busy_now", 32'(busy), 32'd0);
    chk("done_now", 32'(done_t), 32'd0);
    chk("overrun_now", 32'(ovr), 32'd0);
    model_done = 1'b0; done_base = 1'b0; exp_ovr = 1'b0;
    cut_after(5);
    #2;
    rst_n = 1'b1;
    run_to(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
